alu_logic_shift_mc: RTL and testbench

Parametrised, multi-cycle successor to the combinational AND/OR/XOR logic unit in the RV32I datapath. It adds SLL/SRL/SRA, executed iteratively at STEP bit positions per cycle, and uses valid/ready handshakes on both input and output. This lets it sit behind a stall-capable issue stage. Logic ops complete in 1 cycle. Shifts take 1 + ceil(shamt/STEP) cycles.

---
 rtl/alu_pkg.sv | 31 +++
 rtl/alu_shift_step.sv | 37 +++
 rtl/alu_logic_shift_mc.sv | 152 +++++++++++++++
 tb/tb_alu_logic_shift_mc.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : alu_pkg
// Description : Shared opcode and state encodings for the multi-cycle
//               logic/shift unit, plus an opcode classification helper.
//               The AND/OR/XOR codes match the existing logic unit.
// Revision    : 1.0 - initial release
// ============================================================================
package alu_pkg;

    typedef enum logic [3:0] {
        ALU_AND = 4'b0100,
        ALU_OR  = 4'b0101,
        ALU_XOR = 4'b0110,
        ALU_SLL = 4'b0111,
        ALU_SRL = 4'b1000,
        ALU_SRA = 4'b1001
    } alu_op_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_e;

    function automatic logic is_shift_op(input logic [3:0] op);
        return (op == ALU_SLL) || (op == ALU_SRL) || (op == ALU_SRA);
    endfunction

endpackage : alu_pkg
`default_nettype wire

// File: rtl/alu_shift_step.sv
`default_nettype none
// ============================================================================
// Module      : alu_shift_step
// Description : Combinational single-step shifter. Shifts work_i by n_i
//               positions (0..STEP) left, or right with zero/sign fill.
// Ports       : work_i    - value being shifted
//               n_i       - shift distance for this step (0..STEP)
//               dir_i     - 0 = left, 1 = right
//               arith_i   - right shifts replicate the sign bit when set
//               shifted_o - shifted value
// Revision    : 1.0 - initial release
// ============================================================================
module alu_shift_step #(
    parameter  int WIDTH = 32,
    parameter  int STEP  = 1,
    localparam int N_W   = $clog2(STEP + 1)
) (
    input  logic [WIDTH-1:0] work_i,
    input  logic [N_W-1:0]   n_i,
    input  logic             dir_i,
    input  logic             arith_i,
    output logic [WIDTH-1:0] shifted_o
);

    always_comb begin
        shifted_o = work_i;
        if (!dir_i) begin
            shifted_o = work_i << n_i;
        end else if (arith_i) begin
            shifted_o = $unsigned($signed(work_i) >>> n_i);
        end else begin
            shifted_o = work_i >> n_i;
        end
    end

endmodule : alu_shift_step
`default_nettype wire

// File: rtl/alu_logic_shift_mc.sv
`default_nettype none
// ============================================================================
// Module      : alu_logic_shift_mc
// Description : Multi-cycle logic/shift unit with valid/ready on both sides.
//               AND/OR/XOR and illegal codes finish in one cycle; shifts
//               iterate STEP positions per cycle in the SHIFT state.
// Ports       : clk, rst_n           - clock, async active-low reset
//               in_valid / in_ready  - request handshake
//               a, b, cntrl          - operands and opcode
//               out_valid / out_ready- result handshake
//               result, illegal_op   - held stable while out_valid
//               busy                 - high while shifting
// Revision    : 1.0 - initial release
// ============================================================================
module alu_logic_shift_mc
    import alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int STEP  = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       cntrl,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             illegal_op,
    output logic             busy
);

    localparam int SHAMT_W = $clog2(WIDTH);
    localparam int N_W     = $clog2(STEP + 1);

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic               illegal_q, illegal_d;
    logic [WIDTH-1:0]   work_q, work_d;
    logic [SHAMT_W-1:0] rem_q, rem_d;
    logic               dir_q, dir_d;
    logic               arith_q, arith_d;

    logic [N_W-1:0]     n_w;
    logic [WIDTH-1:0]   shifted_w;

    // Distance for this cycle: min(STEP, remaining). Compared as int so a
    // STEP equal to WIDTH does not overflow the shift-amount width.
    always_comb begin
        n_w = N_W'(STEP);
        if (int'(rem_q) < STEP) begin
            n_w = N_W'(rem_q);
        end
    end

    alu_shift_step #(
        .WIDTH (WIDTH),
        .STEP  (STEP)
    ) u_shift_step (
        .work_i    (work_q),
        .n_i       (n_w),
        .dir_i     (dir_q),
        .arith_i   (arith_q),
        .shifted_o (shifted_w)
    );

    always_comb begin
        state_d   = state_q;
        result_d  = result_q;
        illegal_d = illegal_q;
        work_d    = work_q;
        rem_d     = rem_q;
        dir_d     = dir_q;
        arith_d   = arith_q;

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    illegal_d = 1'b0;
                    state_d   = DONE;
                    if (is_shift_op(cntrl)) begin
                        // Direction and fill are captured here so later
                        // changes on cntrl cannot affect the running shift.
                        work_d  = a;
                        rem_d   = b[SHAMT_W-1:0];
                        dir_d   = (cntrl != ALU_SLL);
                        arith_d = (cntrl == ALU_SRA);
                        if (b[SHAMT_W-1:0] == '0) begin
                            result_d = a;
                        end else begin
                            state_d = SHIFT;
                        end
                    end else begin
                        case (cntrl)
                            ALU_AND: result_d = a & b;
                            ALU_OR:  result_d = a | b;
                            ALU_XOR: result_d = a ^ b;
                            default: begin
                                result_d  = '0;
                                illegal_d = 1'b1;
                            end
                        endcase
                    end
                end
            end
            SHIFT: begin
                work_d = shifted_w;
                rem_d  = rem_q - SHAMT_W'(n_w);
                if (rem_q == SHAMT_W'(n_w)) begin
                    result_d = shifted_w;
                    state_d  = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            result_q  <= '0;
            illegal_q <= 1'b0;
            work_q    <= '0;
            rem_q     <= '0;
            dir_q     <= 1'b0;
            arith_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            result_q  <= result_d;
            illegal_q <= illegal_d;
            work_q    <= work_d;
            rem_q     <= rem_d;
            dir_q     <= dir_d;
            arith_q   <= arith_d;
        end
    end

    assign in_ready   = (state_q == IDLE);
    assign out_valid  = (state_q == DONE);
    assign busy       = (state_q == SHIFT);
    assign result     = result_q;
    assign illegal_op = illegal_q;

endmodule : alu_logic_shift_mc
`default_nettype wire

// File: tb/tb_alu_logic_shift_mc.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_logic_shift_mc
// Description : Directed bench for alu_logic_shift_mc, with one STEP=1 and
//               one STEP=4 instance sharing operands and reset.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_logic_shift_mc;
    import alu_pkg::*;

    logic        clk;
    logic        rst_n;
    logic [31:0] a, b;
    logic [3:0]  cntrl;
    logic        out_ready;
    logic        v1, v4;

    logic        ir1, ov1, il1, bz1;
    logic        ir4, ov4, il4, bz4;
    logic [31:0] rs1, rs4;

    int          sel;
    logic        ir, ov, il, bz;
    logic [31:0] rs;

    int total = 0;
    int bad   = 0;

    alu_logic_shift_mc #(.WIDTH(32), .STEP(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(v1), .in_ready(ir1),
        .a(a), .b(b), .cntrl(cntrl), .out_valid(ov1), .out_ready(out_ready),
        .result(rs1), .illegal_op(il1), .busy(bz1)
    );

    alu_logic_shift_mc #(.WIDTH(32), .STEP(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .in_valid(v4), .in_ready(ir4),
        .a(a), .b(b), .cntrl(cntrl), .out_valid(ov4), .out_ready(out_ready),
        .result(rs4), .illegal_op(il4), .busy(bz4)
    );

    always_comb begin
        ir = (sel == 1) ? ir4 : ir1;
        ov = (sel == 1) ? ov4 : ov1;
        il = (sel == 1) ? il4 : il1;
        bz = (sel == 1) ? bz4 : bz1;
        rs = (sel == 1) ? rs4 : rs1;
    end

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Issue one request, measure cycles from accept to out_valid, check the
    // result, then complete the handshake and confirm return to IDLE.
    task automatic run(input int s, input logic [3:0] op, input logic [31:0] av,
                       input logic [31:0] bv, input int exp_lat,
                       input logic [31:0] exp_res, input logic exp_ill,
                       input int exp_busy, input string tag);
        int lat;
        int bcnt;
        sel = s;
        @(negedge clk);
        a = av; b = bv; cntrl = op;
        v1 = (s == 0); v4 = (s == 1);
        chk({tag, "/in_ready"}, 32'(ir), 32'd1);
        @(posedge clk);
        #1;
        v1 = 1'b0; v4 = 1'b0;
        lat = 1; bcnt = 0;
        while (!ov && lat < 200) begin
            if (bz) bcnt++;
            @(posedge clk);
            #1;
            lat++;
        end
        chk({tag, "/lat"}, 32'(lat), 32'(exp_lat));
        chk({tag, "/res"}, rs, exp_res);
        chk({tag, "/ill"}, 32'(il), 32'(exp_ill));
        chk({tag, "/busy"}, 32'(bcnt), 32'(exp_busy));
        @(posedge clk);
        #1;
        chk({tag, "/idle"}, {30'd0, ir, ov}, 32'h2);
    endtask

    initial begin
        logic seen;
        sel = 0;
        rst_n = 1'b0;
        a = '0; b = '0; cntrl = '0;
        v1 = 1'b0; v4 = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("rst/in_ready", 32'(ir1), 32'd1);
        chk("rst/out_valid", 32'(ov1), 32'd0);
        chk("rst/result", rs1, 32'd0);
        chk("rst/illegal", 32'(il1), 32'd0);
        chk("rst/busy", 32'(bz1), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Logic ops, STEP=1
        run(0, ALU_AND, 32'hF0F0_1234, 32'h0FF0_FFFF, 1, 32'h00F0_1234, 1'b0, 0, "and");
        run(0, ALU_OR,  32'hF0F0_1234, 32'h0FF0_FFFF, 1, 32'hFFF0_FFFF, 1'b0, 0, "or");
        run(0, ALU_XOR, 32'hF0F0_1234, 32'h0FF0_FFFF, 1, 32'hFF00_EDCB, 1'b0, 0, "xor");

        // Maximum-latency shifts, STEP=1
        run(0, ALU_SRA, 32'h8000_0000, 32'd31, 32, 32'hFFFF_FFFF, 1'b0, 31, "sra31");
        run(0, ALU_SRL, 32'h8000_0000, 32'd31, 32, 32'h0000_0001, 1'b0, 31, "srl31");

        // STEP=4 shifts, including shamt=0 and upper shamt bits ignored
        run(1, ALU_SLL, 32'h0000_0001, 32'h0000_0025, 3, 32'h0000_0020, 1'b0, 2, "sll5");
        run(1, ALU_SLL, 32'hDEAD_BEEF, 32'h0000_0020, 1, 32'hDEAD_BEEF, 1'b0, 0, "sll0");
        run(1, ALU_SLL, 32'h0000_0001, 32'd35, 2, 32'h0000_0008, 1'b0, 1, "sll35");
        run(1, ALU_SRA, 32'h8000_00F0, 32'd8, 3, 32'hFF80_0000, 1'b0, 2, "sra8");

        // Illegal opcode, then a legal op clears the flag
        run(0, 4'b1111, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1, 32'h0, 1'b1, 0, "illegal");
        run(0, ALU_AND, 32'hFFFF_0000, 32'h00FF_FF00, 1, 32'h00FF_0000, 1'b0, 0, "and_after");

        // Backpressure: result held, second request waits
        sel = 0;
        @(negedge clk);
        a = 32'hF0F0_1234; b = 32'h0FF0_FFFF; cntrl = ALU_AND;
        v1 = 1'b1; out_ready = 1'b0;
        @(posedge clk);
        #1;
        cntrl = ALU_OR;
        for (int i = 0; i < 10; i++) begin
            chk("hold/res", rs, 32'h00F0_1234);
            chk("hold/flags", {30'd0, ir, ov}, 32'h1);
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("release/idle", {30'd0, ir, ov}, 32'h2);
        @(posedge clk);
        #1;
        v1 = 1'b0;
        chk("pending/ov", 32'(ov), 32'd1);
        chk("pending/res", rs, 32'hFFF0_FFFF);
        @(posedge clk);
        #1;
        chk("pending/idle", 32'(ir), 32'd1);

        // Reset in the middle of a shift
        sel = 0;
        @(negedge clk);
        a = 32'h1234_5678; b = 32'd20; cntrl = ALU_SRL; v1 = 1'b1;
        @(posedge clk);
        #1;
        v1 = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        chk("midrst/busy_before", 32'(bz), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst/ov", 32'(ov), 32'd0);
        chk("midrst/res", rs, 32'd0);
        chk("midrst/in_ready", 32'(ir), 32'd1);
        chk("midrst/busy", 32'(bz), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(posedge clk);
            #1;
            if (ov) seen = 1'b1;
        end
        chk("midrst/no_out", 32'(seen), 32'd0);
        chk("midrst/idle", 32'(ir), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_alu_logic_shift_mc
`default_nettype wire
